encoder: RTL and testbench

Registered 16-to-4 priority encoder with input-stability qualification; the reverse direction of the team's clocked 4-to-16 decoder. It accepts a 16-bit one-hot word, waits until the word has been stable for a programmable number of cycles, then presents the 4-bit index with a valid level, a one-cycle strobe, and a flag for non-one-hot words. It sits on the decoder's output side, both for loopback checking (decoder out -> encoder in -> compare with decoder in) and as a standalone block in the trojan test designs.

---
 rtl/encoder_if.sv | 13 +
 rtl/encoder.sv | 144 ++++++++++++++
 tb/tb_encoder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_if.sv
// Bus between a one-hot word source and the encoder: the word goes in,
// the encoded index and its qualifiers come back.
interface encoder_if;
    logic [15:0] in;
    logic [3:0]  out;
    logic        valid;
    logic        strobe;
    logic        err;
    logic [7:0]  err_count;

    modport master (output in, input out, valid, strobe, err, err_count);
    modport slave  (input in, output out, valid, strobe, err, err_count);
endinterface

// File: rtl/encoder.sv
// Registered 16-to-4 priority encoder. A word must be held for STABLE_CYCLES
// sampling edges before its index is accepted and presented.
module encoder #(
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic      clk,
    input  logic      reset,
    encoder_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] CNT_SAT  = 4'(STABLE_CYCLES);
    localparam logic [4:0] CNT_TGT  = 5'(STABLE_CYCLES);
    localparam bit         ONE_EDGE = (STABLE_CYCLES == 32'd1);

    logic [1:0]  state_q, state_d;
    logic [15:0] in_q, in_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  out_q, out_d;
    logic        valid_q, valid_d;
    logic        strobe_q, strobe_d;
    logic        err_q, err_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        changed_s;
    logic        accept_s;
    logic [15:0] accept_word_s;
    logic [3:0]  msb_s;
    logic        multi_s;

    // Highest set bit wins, so multi-hot words still produce a usable index.
    function automatic logic [3:0] msb_index(input logic [15:0] w);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            idx = w[i] ? 4'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [4:0] pop_count(input logic [15:0] w);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, w[i]};
        end
        return n;
    endfunction

    // Acceptance decision; with a single-edge window a fresh nonzero word is accepted on arrival.
    always_comb begin
        changed_s = (bus.in != in_q);
        if (changed_s) begin
            accept_word_s = bus.in;
            accept_s      = ONE_EDGE && (bus.in != 16'd0);
        end else begin
            accept_word_s = in_q;
            accept_s      = (state_q == ST_SETTLE) && (({1'b0, cnt_q} + 5'd1) >= CNT_TGT);
        end
        msb_s   = msb_index(accept_word_s);
        multi_s = (pop_count(accept_word_s) > 5'd1);
    end

    // Next-state logic: a changed word restarts settling, acceptance overrides it.
    always_comb begin
        state_d     = state_q;
        in_d        = in_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        valid_d     = valid_q;
        strobe_d    = 1'b0;
        err_d       = err_q;
        err_count_d = err_count_q;

        if (changed_s) begin
            in_d    = bus.in;
            cnt_d   = 4'd1;
            valid_d = 1'b0;
            state_d = (bus.in == 16'd0) ? ST_IDLE : ST_SETTLE;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    cnt_d = accept_s ? cnt_q : (cnt_q + 4'd1);
                end
                ST_IDLE, ST_LOCKED: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end

        if (accept_s) begin
            out_d    = msb_s;
            err_d    = multi_s;
            valid_d  = 1'b1;
            strobe_d = 1'b1;
            state_d  = ST_LOCKED;
            cnt_d    = CNT_SAT;
            if (multi_s && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end else begin
                err_count_d = err_count_q;
            end
        end else begin
            strobe_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            in_q        <= 16'd0;
            cnt_q       <= 4'd0;
            out_q       <= 4'd0;
            valid_q     <= 1'b0;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            in_q        <= in_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            strobe_q    <= strobe_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.valid     = valid_q;
    assign bus.strobe    = strobe_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench: two encoders (window 2 and window 1) share stimulus and
// are compared every edge against a word-age reference model.
module tb_encoder;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    encoder_if bus0 ();
    encoder_if bus1 ();

    encoder #(.STABLE_CYCLES(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    encoder #(.STABLE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    logic [14:0] obs [2];
    assign obs[0] = {bus0.out, bus0.valid, bus0.strobe, bus0.err, bus0.err_count};
    assign obs[1] = {bus1.out, bus1.valid, bus1.strobe, bus1.err, bus1.err_count};

    int          ns [2] = '{2, 1};
    logic [15:0] m_word [2];
    int          m_age [2];
    logic [3:0]  m_out [2];
    bit          m_valid [2];
    bit          m_strobe [2];
    bit          m_err [2];
    int          m_cnt [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Age of the current word in sampling edges; acceptance happens when it reaches the window.
    task automatic model_edge(input int d, input logic [15:0] v, input logic r);
        if (!r) begin
            m_word[d] = 16'd0; m_age[d] = 0; m_out[d] = 4'd0;
            m_valid[d] = 1'b0; m_strobe[d] = 1'b0; m_err[d] = 1'b0; m_cnt[d] = 0;
        end else begin
            if (v != m_word[d]) begin
                m_word[d] = v;
                m_age[d]  = 1;
            end else if (m_age[d] <= ns[d]) begin
                m_age[d] = m_age[d] + 1;
            end
            m_strobe[d] = (m_word[d] != 16'd0) && (m_age[d] == ns[d]);
            if (m_strobe[d]) begin
                m_out[d] = 4'($clog2({1'b0, m_word[d]} + 17'd1) - 1);
                m_err[d] = ($countones(m_word[d]) > 1);
                if (m_err[d] && m_cnt[d] < 255) m_cnt[d] = m_cnt[d] + 1;
            end
            m_valid[d] = (m_word[d] != 16'd0) && (m_age[d] >= ns[d]);
        end
    endtask

    function automatic logic [14:0] exp_vec(input int d);
        return {m_out[d], m_valid[d], m_strobe[d], m_err[d], 8'(m_cnt[d])};
    endfunction

    task automatic tick(input logic [15:0] v, input logic r);
        bus0.in = v;
        bus1.in = v;
        reset   = r;
        @(posedge clk);
        model_edge(0, v, r);
        model_edge(1, v, r);
        #1;
    endtask

    task automatic test_reset();
        for (int e = 0; e < 2; e++) begin
            tick(16'h0040, 1'b0);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== 15'd0) begin
                    n_fail++;
                    $display("FAIL reset dut%0d edge %0d: got %h expected %h", d, e, obs[d], 15'd0);
                end
            end
        end
    endtask

    task automatic test_onehot_sweep();
        for (int i = 0; i < 16; i++) begin
            int strobes;
            int strobe_edge;
            strobes = 0;
            strobe_edge = -1;
            for (int e = 0; e < 6; e++) begin
                tick(16'h0001 << i, 1'b1);
                if (bus0.strobe) begin strobes++; strobe_edge = e; end
                for (int d = 0; d < 2; d++) begin
                    n_checks++;
                    if (obs[d] !== exp_vec(d)) begin
                        n_fail++;
                        $display("FAIL sweep bit %0d dut%0d edge %0d: got %h expected %h", i, d, e, obs[d], exp_vec(d));
                    end
                end
            end
            n_checks++;
            if (bus0.out !== 4'(i) || bus0.valid !== 1'b1 || bus0.err !== 1'b0 || strobes != 1 || strobe_edge != 1) begin
                n_fail++;
                $display("FAIL sweep_direct bit %0d: got out=%0d valid=%b err=%b strobes=%0d at edge %0d expected out=%0d valid=1 err=0 strobes=1 at edge 1",
                         i, bus0.out, bus0.valid, bus0.err, strobes, strobe_edge, i);
            end
        end
    endtask

    task automatic test_multi_hot();
        logic [15:0] words [2] = '{16'h8001, 16'h0101};
        logic [3:0]  idx   [2] = '{4'd15, 4'd8};
        for (int w = 0; w < 2; w++) begin
            for (int e = 0; e < 4; e++) begin
                tick(words[w], 1'b1);
                for (int d = 0; d < 2; d++) begin
                    n_checks++;
                    if (obs[d] !== exp_vec(d)) begin
                        n_fail++;
                        $display("FAIL multi %h dut%0d edge %0d: got %h expected %h", words[w], d, e, obs[d], exp_vec(d));
                    end
                end
            end
            n_checks++;
            if (bus0.out !== idx[w] || bus0.err !== 1'b1 || bus0.err_count !== 8'(w + 1)) begin
                n_fail++;
                $display("FAIL multi_direct %h: got out=%0d err=%b cnt=%0d expected out=%0d err=1 cnt=%0d",
                         words[w], bus0.out, bus0.err, bus0.err_count, idx[w], w + 1);
            end
        end
    endtask

    task automatic test_glitch();
        logic [15:0] seq [9] = '{16'h0010, 16'h0010, 16'h0010, 16'h0004,
                                 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010};
        int strobes;
        strobes = 0;
        for (int e = 0; e < 9; e++) begin
            tick(seq[e], 1'b1);
            if (e >= 4 && bus0.strobe) strobes++;
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== exp_vec(d)) begin
                    n_fail++;
                    $display("FAIL glitch dut%0d edge %0d: got %h expected %h", d, e, obs[d], exp_vec(d));
                end
            end
            if (e == 3) begin
                n_checks++;
                if (bus0.out !== 4'd4 || bus0.valid !== 1'b0 || bus0.strobe !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch_hold: got out=%0d valid=%b strobe=%b expected out=4 valid=0 strobe=0",
                             bus0.out, bus0.valid, bus0.strobe);
                end
            end
        end
        n_checks++;
        if (strobes != 1 || bus0.out !== 4'd4 || bus0.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_reaccept: got strobes=%0d out=%0d valid=%b expected strobes=1 out=4 valid=1",
                     strobes, bus0.out, bus0.valid);
        end
    endtask

    task automatic test_zero_and_mid_reset();
        for (int e = 0; e < 3; e++) begin
            tick(16'h0000, 1'b1);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== exp_vec(d)) begin
                    n_fail++;
                    $display("FAIL zero dut%0d edge %0d: got %h expected %h", d, e, obs[d], exp_vec(d));
                end
            end
        end
        n_checks++;
        if (bus0.valid !== 1'b0 || bus0.out !== 4'd4) begin
            n_fail++;
            $display("FAIL zero_direct: got valid=%b out=%0d expected valid=0 out=4", bus0.valid, bus0.out);
        end
        tick(16'h0020, 1'b1);
        tick(16'h0020, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== 15'd0) begin
                n_fail++;
                $display("FAIL mid_reset dut%0d: got %h expected %h", d, obs[d], 15'd0);
            end
        end
    endtask

    task automatic test_saturation();
        for (int a = 0; a < 300; a++) begin
            for (int e = 0; e < 3; e++) begin
                tick((a % 2 == 0) ? 16'h0003 : 16'h0300, 1'b1);
                for (int d = 0; d < 2; d++) begin
                    n_checks++;
                    if (obs[d] !== exp_vec(d)) begin
                        n_fail++;
                        $display("FAIL saturation acc %0d dut%0d: got %h expected %h", a, d, obs[d], exp_vec(d));
                    end
                end
            end
        end
        n_checks++;
        if (bus0.err_count !== 8'd255 || bus0.err !== 1'b1 || bus1.err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL saturation_direct: got cnt0=%0d err0=%b cnt1=%0d expected 255 1 255",
                     bus0.err_count, bus0.err, bus1.err_count);
        end
    endtask

    task automatic test_random();
        logic [15:0] word;
        logic        r;
        word = 16'h0000;
        for (int k = 0; k < 200; k++) begin
            int sel;
            int hold;
            sel  = $urandom_range(0, 5);
            hold = $urandom_range(1, 4);
            r    = 1'b1;
            case (sel)
                0:       word = 16'h0000;
                1, 2:    word = 16'h0001 << $urandom_range(0, 15);
                3:       word = 16'($urandom());
                4:       word = word;
                default: r = 1'b0;
            endcase
            for (int e = 0; e < hold; e++) begin
                tick(word, r);
                for (int d = 0; d < 2; d++) begin
                    n_checks++;
                    if (obs[d] !== exp_vec(d)) begin
                        n_fail++;
                        $display("FAIL random step %0d dut%0d word %h: got %h expected %h", k, d, word, obs[d], exp_vec(d));
                    end
                end
            end
        end
    endtask

    initial begin
        bus0.in = 16'h0000;
        bus1.in = 16'h0000;
        reset   = 1'b0;
        test_reset();
        test_onehot_sweep();
        test_multi_hot();
        test_glitch();
        test_zero_and_mid_reset();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
